// File: rtl/montgomery_redc_pipe_if.sv
// Config, input and output channels of montgomery_redc_pipe.
// Under MONT_REDC_RANGE_CHECK_EN the output channel also carries out_range_err_o.
interface montgomery_redc_pipe_if #(
  parameter int W     = 64,
  parameter int TAG_W = 4
);
  localparam int KW = $clog2(W + 1);

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [W-1:0]     cfg_q_i;
  logic [W-1:0]     cfg_qinv_i;
  logic [KW-1:0]    cfg_k_i;
  logic             cfg_err_o;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2*W-1:0]   in_x_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     out_res_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             busy_o;
`ifdef MONT_REDC_RANGE_CHECK_EN
  logic             out_range_err_o;
`endif

  modport slave (
    input  cfg_valid_i, cfg_q_i, cfg_qinv_i, cfg_k_i,
    input  in_valid_i, in_x_i, in_tag_i, out_ready_i,
    output cfg_ready_o, cfg_err_o, in_ready_o,
    output out_valid_o, out_res_o, out_tag_o, busy_o
`ifdef MONT_REDC_RANGE_CHECK_EN
    , output out_range_err_o
`endif
  );

  modport master (
    output cfg_valid_i, cfg_q_i, cfg_qinv_i, cfg_k_i,
    output in_valid_i, in_x_i, in_tag_i, out_ready_i,
    input  cfg_ready_o, cfg_err_o, in_ready_o,
    input  out_valid_o, out_res_o, out_tag_o, busy_o
`ifdef MONT_REDC_RANGE_CHECK_EN
    , input out_range_err_o
`endif
  );
endinterface

// File: rtl/montgomery_redc_pipe.sv
// Pipelined REDC x*2^-k mod q, latency 2*MUL_LAT+4 edges; whole pipe freezes while the output is held (no skid).
// Optional MONT_REDC_RANGE_CHECK_EN adds out_range_err_o flagging x >= q*2^k or t >= 2q.
module montgomery_redc_pipe #(
  parameter int W       = 64,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  montgomery_redc_pipe_if.slave bus
);
  localparam int KW  = $clog2(W + 1);
  localparam int NST = 2 * MUL_LAT + 4;
  localparam logic [KW-1:0] K_MAX = KW'(W);

  typedef enum logic [1:0] {UNCFG, IDLE, RUN} state_e;
  state_e state_q, state_d;

  logic [W-1:0]     q_q, qinv_q;
  logic [KW-1:0]    k_q;
  logic             cfg_err_q;
  logic [NST-1:0]   vld_q, vld_d;
  logic [W-1:0]     res_q;
  logic [TAG_W-1:0] otag_q;
  logic             cfg_ready, cfg_acc, k_ok, adv, in_ready, in_fire;
  logic [W-1:0]     mask, lsb, res_d;
  logic [2*W:0]     sum;

  logic [2*W-1:0]   x0_q;
  logic [TAG_W-1:0] tag0_q;
  logic [W-1:0]     p1_q   [MUL_LAT];
  logic [2*W-1:0]   xa_q   [MUL_LAT];
  logic [TAG_W-1:0] taga_q [MUL_LAT];
  logic [W-1:0]     m_q;
  logic [2*W-1:0]   x1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [2*W-1:0]   p2_q   [MUL_LAT];
  logic [2*W-1:0]   xb_q   [MUL_LAT];
  logic [TAG_W-1:0] tagb_q [MUL_LAT];
  logic [W:0]       t_q;
  logic [TAG_W-1:0] tag2_q;

  // Built one bit wider so k = W yields all ones.
  assign mask  = W'(((W + 1)'(1) << k_q) - (W + 1)'(1));
  assign lsb   = x0_q[W-1:0] & mask;
  assign sum   = {1'b0, xb_q[MUL_LAT-1]} + {1'b0, p2_q[MUL_LAT-1]};
  assign res_d = (t_q >= {1'b0, q_q}) ? W'(t_q - {1'b0, q_q}) : W'(t_q);
  assign k_ok  = (bus.cfg_k_i != '0) && (bus.cfg_k_i <= K_MAX);
  assign adv   = ~vld_q[NST-1] | bus.out_ready_i;

  always_comb begin
    state_d   = state_q;
    cfg_ready = (state_q != RUN);
    cfg_acc   = bus.cfg_valid_i & cfg_ready;
    in_ready  = adv & (state_q != UNCFG) & ~cfg_acc;
    in_fire   = bus.in_valid_i & in_ready;
    vld_d     = adv ? {vld_q[NST-2:0], in_fire} : vld_q;
    unique case (state_q)
      UNCFG:   state_d = UNCFG;
      IDLE:    if (in_fire) state_d = RUN;
      RUN:     if (vld_d == '0) state_d = IDLE;
      default: state_d = UNCFG;
    endcase
    if (cfg_acc) state_d = k_ok ? IDLE : UNCFG;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= UNCFG;
      vld_q     <= '0;
      q_q       <= '0;
      qinv_q    <= '0;
      k_q       <= '0;
      cfg_err_q <= 1'b0;
      res_q     <= '0;
      otag_q    <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      if (cfg_acc) begin
        cfg_err_q <= ~k_ok;
        if (k_ok) begin
          q_q    <= bus.cfg_q_i;
          qinv_q <= bus.cfg_qinv_i;
          k_q    <= bus.cfg_k_i;
        end
      end
      if (adv && vld_q[NST-2]) begin
        res_q  <= res_d;
        otag_q <= tag2_q;
      end
    end
  end

  // Payload registers need no reset: bubbles are tracked by vld_q alone.
  always_ff @(posedge clk_i) begin
    if (adv) begin
      x0_q      <= bus.in_x_i;
      tag0_q    <= bus.in_tag_i;
      p1_q[0]   <= lsb * qinv_q;
      xa_q[0]   <= x0_q;
      taga_q[0] <= tag0_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        p1_q[i]   <= p1_q[i-1];
        xa_q[i]   <= xa_q[i-1];
        taga_q[i] <= taga_q[i-1];
      end
      m_q       <= p1_q[MUL_LAT-1] & mask;
      x1_q      <= xa_q[MUL_LAT-1];
      tag1_q    <= taga_q[MUL_LAT-1];
      p2_q[0]   <= {{W{1'b0}}, m_q} * {{W{1'b0}}, q_q};
      xb_q[0]   <= x1_q;
      tagb_q[0] <= tag1_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        p2_q[i]   <= p2_q[i-1];
        xb_q[i]   <= xb_q[i-1];
        tagb_q[i] <= tagb_q[i-1];
      end
      t_q    <= (W + 1)'(sum >> k_q);
      tag2_q <= tagb_q[MUL_LAT-1];
    end
  end

`ifdef MONT_REDC_RANGE_CHECK_EN
  logic [2*W:0] q_shk;
  logic         rng0_q, r1_q, r2_q, rng_q;
  logic         ra_q [MUL_LAT];
  logic         rb_q [MUL_LAT];

  assign q_shk = {{(W + 1){1'b0}}, q_q} << k_q;

  always_ff @(posedge clk_i) begin
    if (adv) begin
      rng0_q  <= ({1'b0, bus.in_x_i} >= q_shk);
      ra_q[0] <= rng0_q;
      for (int i = 1; i < MUL_LAT; i++) ra_q[i] <= ra_q[i-1];
      r1_q    <= ra_q[MUL_LAT-1];
      rb_q[0] <= r1_q;
      for (int i = 1; i < MUL_LAT; i++) rb_q[i] <= rb_q[i-1];
      r2_q    <= rb_q[MUL_LAT-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                      rng_q <= 1'b0;
    else if (adv && vld_q[NST-2])   rng_q <= r2_q | (t_q >= {q_q, 1'b0});
  end

  assign bus.out_range_err_o = rng_q;
`endif

  assign bus.cfg_ready_o = cfg_ready;
  assign bus.cfg_err_o   = cfg_err_q;
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = vld_q[NST-1];
  assign bus.out_res_o   = res_q;
  assign bus.out_tag_o   = otag_q;
  assign bus.busy_o      = |vld_q;
endmodule

// File: tb/tb_montgomery_redc_pipe.sv
// Directed bench for montgomery_redc_pipe at W=64, MUL_LAT=3; expected residues derived by hand
// (q=17, k=5: 2^-5 mod 17 = 8; q=2^61-1, k=61: 2^61 = 1 mod q).
module tb_montgomery_redc_pipe;
  localparam int W = 64, MUL_LAT = 3, TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  montgomery_redc_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();
  montgomery_redc_pipe #(.W(W), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] stim_x[$];
  logic [3:0]   stim_tag[$];
  logic [63:0]  stim_exp[$];
  logic [63:0]  exp_res[$];
  logic [3:0]   exp_tag[$];
  int first_lat, first_out_cyc, last_out_cyc;
  logic last_busy;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [63:0] q, input logic [63:0] qinv, input logic [6:0] k);
    @(negedge clk);
    bus.cfg_valid_i = 1'b1;
    bus.cfg_q_i     = q;
    bus.cfg_qinv_i  = qinv;
    bus.cfg_k_i     = k;
    #1;
    for (int i = 0; i < 50 && !bus.cfg_ready_o; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("cfg_accept", bus.cfg_ready_o, 1);
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    #1;
  endtask

  // model q=17, k=5: x*2^-5 mod 17 = (x mod 17)*8 mod 17
  task automatic push_q17(input logic [127:0] x, input logic [3:0] tag);
    stim_x.push_back(x);
    stim_tag.push_back(tag);
    stim_exp.push_back(64'(((x % 17) * 8) % 17));
  endtask

  task automatic run_stream(input bit rnd_rdy, input int budget);
    int cyc, sent, got;
    int acc_cyc[$];
    bit prev_stall;
    logic [63:0] prev_res;
    logic [3:0]  prev_tag;
    cyc = 0; got = 0; prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
    sent = stim_x.size();
    first_lat = -1; first_out_cyc = -1; last_out_cyc = -1; last_busy = 1'b0;
    while (got < sent) begin
      @(negedge clk);
      cyc++;
      if (cyc > budget) begin
        check_eq("stream_done", got, sent);
        break;
      end
      bus.in_valid_i = (stim_x.size() != 0);
      if (stim_x.size() != 0) begin
        bus.in_x_i   = stim_x[0];
        bus.in_tag_i = stim_tag[0];
      end
      bus.out_ready_i = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (prev_stall) begin
        check_eq("hold_valid", bus.out_valid_o, 1);
        check_eq("hold_res", bus.out_res_o, prev_res);
        check_eq("hold_tag", bus.out_tag_o, prev_tag);
      end
      if (bus.out_valid_o && !bus.out_ready_i) check_eq("in_ready_stall", bus.in_ready_o, 0);
      if (bus.in_valid_i && bus.in_ready_o) begin
        void'(stim_x.pop_front());
        exp_tag.push_back(stim_tag.pop_front());
        exp_res.push_back(stim_exp.pop_front());
        acc_cyc.push_back(cyc);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_res.size() == 0) begin
          check_eq("spurious_out", bus.out_valid_o, 0);
        end else begin
          check_eq("res", bus.out_res_o, exp_res.pop_front());
          check_eq("tag", bus.out_tag_o, exp_tag.pop_front());
          if (first_lat < 0) first_lat = cyc - acc_cyc[0];
          void'(acc_cyc.pop_front());
          if (first_out_cyc < 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          last_busy    = bus.busy_o;
          got++;
        end
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      prev_res   = bus.out_res_o;
      prev_tag   = bus.out_tag_o;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] big_q, big_x;
    int seen_vld;
    bus.cfg_valid_i = 1'b0; bus.cfg_q_i = '0; bus.cfg_qinv_i = '0; bus.cfg_k_i = '0;
    bus.in_valid_i  = 1'b1; bus.in_x_i  = 128'd100; bus.in_tag_i = '0;
    bus.out_ready_i = 1'b1;

    // 1: reset state, no input accepted while unconfigured
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid_o, 0);
    check_eq("rst_out_res", bus.out_res_o, 0);
    check_eq("rst_out_tag", bus.out_tag_o, 0);
    check_eq("rst_cfg_err", bus.cfg_err_o, 0);
    check_eq("rst_cfg_ready", bus.cfg_ready_o, 1);
    check_eq("uncfg_in_ready", bus.in_ready_o, 0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("uncfg_busy", bus.busy_o, 0);
    bus.in_valid_i = 1'b0;
    do_cfg(64'd17, 64'd15, 7'd5);
    check_eq("cfg_err_ok", bus.cfg_err_o, 0);
    check_eq("idle_cfg_ready", bus.cfg_ready_o, 1);
    check_eq("idle_in_ready", bus.in_ready_o, 1);

    // 2: single transaction and its latency
    push_q17(128'd100, 4'd3);
    run_stream(1'b0, 50);
    check_eq("latency", first_lat, 10);

    // 3: back-to-back
    push_q17(128'd0, 4'd0);
    push_q17(128'd100, 4'd1);
    push_q17(128'd543, 4'd2);
    run_stream(1'b0, 50);
    check_eq("b2b_span", last_out_cyc - first_out_cyc, 2);
    check_eq("busy_at_last", last_busy, 1);
    @(negedge clk);
    #1;
    check_eq("busy_drained", bus.busy_o, 0);

    // 4: random stream with random backpressure
    for (int i = 0; i < 20; i++) push_q17(128'($urandom_range(0, 543)), 4'(i));
    run_stream(1'b1, 500);

    // 5: configuration refused while running, accepted once drained
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1; bus.in_x_i = 128'd100; bus.in_tag_i = 4'd5;
    #1;
    check_eq("run_in_ready", bus.in_ready_o, 1);
    @(negedge clk);
    bus.in_valid_i  = 1'b0;
    bus.cfg_valid_i = 1'b1; bus.cfg_q_i = 64'd17; bus.cfg_qinv_i = 64'd15; bus.cfg_k_i = 7'd5;
    #1;
    check_eq("run_cfg_ready", bus.cfg_ready_o, 0);
    repeat (14) @(negedge clk);
    #1;
    check_eq("stall_cfg_ready", bus.cfg_ready_o, 0);
    check_eq("stall_valid", bus.out_valid_o, 1);
    check_eq("stall_res", bus.out_res_o, 1);
    check_eq("stall_tag", bus.out_tag_o, 5);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.cfg_ready_o) break;
    end
    check_eq("drain_cfg_ready", bus.cfg_ready_o, 1);
    check_eq("drain_busy", bus.busy_o, 0);
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    #1;
    check_eq("recfg_err", bus.cfg_err_o, 0);

    // 5: illegal k
    do_cfg(64'd17, 64'd15, 7'd0);
    check_eq("k0_err", bus.cfg_err_o, 1);
    check_eq("k0_uncfg", bus.in_ready_o, 0);
    do_cfg(64'd17, 64'd15, 7'd65);
    check_eq("k65_err", bus.cfg_err_o, 1);
    check_eq("k65_uncfg", bus.in_ready_o, 0);

    // 5: full width, q = 2^61-1, qinv = 1, x = (q-1)^2 -> 1
    big_q = (128'd1 << 61) - 128'd1;
    big_x = (big_q - 128'd1) * (big_q - 128'd1);
    do_cfg(64'(big_q), 64'd1, 7'd61);
    check_eq("big_cfg_err", bus.cfg_err_o, 0);
    stim_x.push_back(big_x);
    stim_tag.push_back(4'd9);
    stim_exp.push_back(64'd1);
    run_stream(1'b0, 50);

    // configuration wins over a simultaneous input in IDLE
    @(negedge clk);
    bus.in_valid_i  = 1'b1; bus.in_x_i = 128'd100; bus.in_tag_i = 4'd1;
    bus.cfg_valid_i = 1'b1; bus.cfg_q_i = 64'd17; bus.cfg_qinv_i = 64'd15; bus.cfg_k_i = 7'd5;
    #1;
    check_eq("cfg_wins_in_ready", bus.in_ready_o, 0);
    @(negedge clk);
    bus.in_valid_i  = 1'b0;
    bus.cfg_valid_i = 1'b0;
    #1;
    check_eq("cfg_wins_busy", bus.busy_o, 0);

`ifdef MONT_REDC_RANGE_CHECK_EN
    begin : rng_blk
      logic        rng[$];
      logic [63:0] rres[$];
      @(negedge clk);
      bus.in_valid_i = 1'b1; bus.in_x_i = 128'd544; bus.in_tag_i = 4'd7;
      #1;
      check_eq("rng_in_ready0", bus.in_ready_o, 1);
      @(negedge clk);
      bus.in_x_i = 128'd100; bus.in_tag_i = 4'd8;
      #1;
      check_eq("rng_in_ready1", bus.in_ready_o, 1);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      for (int i = 0; i < 30 && rng.size() < 2; i++) begin
        @(negedge clk);
        #1;
        if (bus.out_valid_o) begin
          rng.push_back(bus.out_range_err_o);
          rres.push_back(bus.out_res_o);
        end
      end
      check_eq("rng_count", rng.size(), 2);
      if (rng.size() == 2) begin
        check_eq("rng_err_544", rng[0], 1);
        check_eq("rng_err_100", rng[1], 0);
        check_eq("rng_res_100", rres[1], 1);
      end
    end
`endif

    // 6: reset with four transactions in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid_i = 1'b1; bus.in_x_i = 128'(100 + i); bus.in_tag_i = 4'(i);
      #1;
      check_eq("pre_rst_in_ready", bus.in_ready_o, 1);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_vld = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.out_valid_o) seen_vld++;
    end
    check_eq("post_rst_no_output", seen_vld, 0);
    check_eq("post_rst_uncfg", bus.in_ready_o, 0);
    check_eq("post_rst_busy", bus.busy_o, 0);
    check_eq("post_rst_cfg_ready", bus.cfg_ready_o, 1);
    check_eq("post_rst_res", bus.out_res_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
